// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-ported memory between instruction fetch and the LSU.
// Optional fairness (bounded IF starvation) is built when ARB_FAIR_EN is defined.
module mem_port_arbiter #(
   parameter int STREAK_MAX  = 4,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   input  logic        if_kill,
   output logic        if_gnt,
   output logic        if_rvalid,
   output logic [31:0] if_rdata,
   input  logic        lsu_req,
   input  logic        lsu_we,
   input  logic [31:0] lsu_addr,
   input  logic [31:0] lsu_wdata,
   input  logic [3:0]  lsu_be,
   output logic        lsu_gnt,
   output logic        lsu_rvalid,
   output logic [31:0] lsu_rdata,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_be,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output logic        bus_err,
   output logic [1:0]  state_dbg
);

   // Handshake: a requester holds req and payload until the cycle its gnt is high;
   // gnt is only issued in IDLE, and each accepted access returns exactly one
   // rvalid pulse unless it is a killed fetch.
   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      BUSY_IF  = 2'd1,
      BUSY_LSU = 2'd2
   } state_t;

   state_t      state, state_nxt;
   logic [7:0]  tmo_cnt;
   logic        kill_pend;
   logic        force_if;
   logic        timeout;
   logic        done;

   assign timeout   = (state != IDLE) && !mem_ack && (tmo_cnt == 8'(TIMEOUT_CYC - 1));
   assign done      = (state != IDLE) && (mem_ack || timeout);
   assign state_dbg = state;

`ifdef ARB_FAIR_EN
   logic [3:0] streak;

   always_ff @(posedge clk) begin
      if (rst) begin
         streak <= 4'd0;
      end else if (if_gnt || (state == IDLE && !if_req)) begin
         streak <= 4'd0;
      end else if (lsu_gnt && if_req && streak != 4'(STREAK_MAX)) begin
         streak <= streak + 4'd1;
      end
   end

   assign force_if = (streak == 4'(STREAK_MAX)) && if_req;
`else
   assign force_if = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (lsu_gnt) begin
               state_nxt = BUSY_LSU;
            end else if (if_gnt) begin
               state_nxt = BUSY_IF;
            end
         end
         BUSY_IF, BUSY_LSU: begin
            if (done) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Grants are gated by rst so a request raised during reset is never accepted.
   always_comb begin
      lsu_gnt = 1'b0;
      if_gnt  = 1'b0;
      mem_req = 1'b0;
      case (state)
         IDLE: begin
            lsu_gnt = lsu_req && !force_if && !rst;
            if_gnt  = if_req && !lsu_gnt && !if_kill && !rst;
         end
         BUSY_IF, BUSY_LSU: mem_req = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst || state == IDLE) begin
         tmo_cnt <= 8'd0;
      end else if (!mem_ack) begin
         tmo_cnt <= tmo_cnt + 8'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         kill_pend <= 1'b0;
      end else if (state == BUSY_IF && !done) begin
         kill_pend <= kill_pend || if_kill;
      end else begin
         kill_pend <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mem_we     <= 1'b0;
         mem_addr   <= 32'd0;
         mem_wdata  <= 32'd0;
         mem_be     <= 4'd0;
         if_rvalid  <= 1'b0;
         if_rdata   <= 32'd0;
         lsu_rvalid <= 1'b0;
         lsu_rdata  <= 32'd0;
         bus_err    <= 1'b0;
      end else begin
         if_rvalid  <= 1'b0;
         lsu_rvalid <= 1'b0;
         bus_err    <= timeout;
         if (lsu_gnt) begin
            mem_we    <= lsu_we;
            mem_addr  <= lsu_addr;
            mem_wdata <= lsu_wdata;
            mem_be    <= lsu_be;
         end else if (if_gnt) begin
            mem_we    <= 1'b0;
            mem_addr  <= if_addr;
            mem_wdata <= 32'd0;
            mem_be    <= 4'hf;
         end
         // A kill arriving on the completing cycle still suppresses the response.
         if (done && state == BUSY_IF && !kill_pend && !if_kill) begin
            if_rvalid <= 1'b1;
            if_rdata  <= mem_ack ? mem_rdata : 32'd0;
         end
         if (done && state == BUSY_LSU) begin
            lsu_rvalid <= 1'b1;
            lsu_rdata  <= (mem_ack && !mem_we) ? mem_rdata : 32'd0;
         end
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: scoreboard queues hold expected response data,
// a monitor pops them on each rvalid pulse.
module tb_mem_port_arbiter;

   logic        clk;
   logic        rst;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_kill;
   logic        if_gnt;
   logic        if_rvalid;
   logic [31:0] if_rdata;
   logic        lsu_req;
   logic        lsu_we;
   logic [31:0] lsu_addr;
   logic [31:0] lsu_wdata;
   logic [3:0]  lsu_be;
   logic        lsu_gnt;
   logic        lsu_rvalid;
   logic [31:0] lsu_rdata;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_be;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic        bus_err;
   logic [1:0]  state_dbg;

   logic [31:0] if_exp_q[$];
   logic [31:0] lsu_exp_q[$];
   int          tests_run = 0;
   int          tests_failed = 0;

   mem_port_arbiter #(.STREAK_MAX(4), .TIMEOUT_CYC(8)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_kill(if_kill), .if_gnt(if_gnt),
      .if_rvalid(if_rvalid), .if_rdata(if_rdata),
      .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
      .lsu_be(lsu_be), .lsu_gnt(lsu_gnt), .lsu_rvalid(lsu_rvalid), .lsu_rdata(lsu_rdata),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .bus_err(bus_err), .state_dbg(state_dbg)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // driver tasks
   task automatic drive_if(input logic req, input logic [31:0] addr);
      if_req  = req;
      if_addr = addr;
   endtask

   task automatic drive_lsu(input logic req, input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [3:0] be);
      lsu_req   = req;
      lsu_we    = we;
      lsu_addr  = addr;
      lsu_wdata = wdata;
      lsu_be    = be;
   endtask

   task automatic drive_mem(input logic ack, input logic [31:0] rdata);
      mem_ack   = ack;
      mem_rdata = rdata;
   endtask

   // scoreboard monitor
   always @(negedge clk) begin
      #2;
      if (if_rvalid) begin
         if (if_exp_q.size() == 0) check("if_rvalid_unexpected", 32'(if_rvalid), 32'd0);
         else check("if_rdata", if_rdata, if_exp_q.pop_front());
      end
      if (lsu_rvalid) begin
         if (lsu_exp_q.size() == 0) check("lsu_rvalid_unexpected", 32'(lsu_rvalid), 32'd0);
         else check("lsu_rdata", lsu_rdata, lsu_exp_q.pop_front());
      end
   end

   initial begin
      logic exp_is_if;
      int   g;
      rst = 1'b1;
      if_kill = 1'b0;
      drive_if(1'b1, 32'h100);
      drive_lsu(1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
      drive_mem(1'b0, 32'd0);

      // reset state
      @(negedge clk); @(negedge clk); #1;
      check("rst_if_gnt", 32'(if_gnt), 32'd0);
      check("rst_mem_req", 32'(mem_req), 32'd0);
      check("rst_mem_addr", mem_addr, 32'd0);
      check("rst_mem_be", 32'(mem_be), 32'd0);
      check("rst_bus_err", 32'(bus_err), 32'd0);
      check("rst_state", 32'(state_dbg), 32'd0);
      @(negedge clk); rst = 1'b0; drive_if(1'b0, 32'd0);

      // fetch, zero-wait
      @(negedge clk); drive_if(1'b1, 32'h100); #1;
      check("f0_if_gnt", 32'(if_gnt), 32'd1);
      check("f0_mem_req", 32'(mem_req), 32'd0);
      if_exp_q.push_back(32'h00500093);
      @(negedge clk); drive_if(1'b0, 32'd0); drive_mem(1'b1, 32'h00500093); #1;
      check("f1_mem_req", 32'(mem_req), 32'd1);
      check("f1_mem_addr", mem_addr, 32'h100);
      check("f1_mem_we", 32'(mem_we), 32'd0);
      @(negedge clk); drive_mem(1'b0, 32'd0); #1;
      check("f2_mem_req", 32'(mem_req), 32'd0);
      check("f2_if_rvalid", 32'(if_rvalid), 32'd1);
      @(negedge clk); #1;
      check("f3_if_rvalid", 32'(if_rvalid), 32'd0);

      // contention: LSU wins, IF follows two cycles later
      @(negedge clk); drive_if(1'b1, 32'h100); drive_lsu(1'b1, 1'b0, 32'h2000, 32'd0, 4'hf); #1;
      check("c0_lsu_gnt", 32'(lsu_gnt), 32'd1);
      check("c0_if_gnt", 32'(if_gnt), 32'd0);
      lsu_exp_q.push_back(32'hcafe0001);
      @(negedge clk); drive_lsu(1'b0, 1'b0, 32'd0, 32'd0, 4'd0); drive_mem(1'b1, 32'hcafe0001); #1;
      check("c1_mem_addr", mem_addr, 32'h2000);
      check("c1_if_gnt", 32'(if_gnt), 32'd0);
      @(negedge clk); drive_mem(1'b0, 32'd0); #1;
      check("c2_if_gnt", 32'(if_gnt), 32'd1);
      check("c2_lsu_rvalid", 32'(lsu_rvalid), 32'd1);
      if_exp_q.push_back(32'h11112222);
      @(negedge clk); drive_if(1'b0, 32'd0); drive_mem(1'b1, 32'h11112222); #1;
      check("c3_mem_addr", mem_addr, 32'h100);
      @(negedge clk); drive_mem(1'b0, 32'd0); #1;
      check("c4_if_rvalid", 32'(if_rvalid), 32'd1);

      // store: payload registered, read data ignored
      @(negedge clk); drive_lsu(1'b1, 1'b1, 32'h3000, 32'hdeadbeef, 4'b0011); #1;
      check("s0_lsu_gnt", 32'(lsu_gnt), 32'd1);
      lsu_exp_q.push_back(32'd0);
      @(negedge clk); drive_lsu(1'b0, 1'b0, 32'd0, 32'd0, 4'd0); drive_mem(1'b1, 32'hffffffff); #1;
      check("s1_mem_we", 32'(mem_we), 32'd1);
      check("s1_mem_wdata", mem_wdata, 32'hdeadbeef);
      check("s1_mem_be", 32'(mem_be), 32'h3);
      @(negedge clk); drive_mem(1'b0, 32'd0); #1;
      check("s2_lsu_rvalid", 32'(lsu_rvalid), 32'd1);

      // kill during BUSY_IF with delayed ack
      @(negedge clk); drive_if(1'b1, 32'h200); #1;
      check("k0_if_gnt", 32'(if_gnt), 32'd1);
      @(negedge clk); drive_if(1'b0, 32'd0); #1;
      check("k1_mem_addr", mem_addr, 32'h200);
      @(negedge clk); if_kill = 1'b1; #1;
      check("k2_mem_req", 32'(mem_req), 32'd1);
      @(negedge clk); if_kill = 1'b0; drive_if(1'b1, 32'h204); #1;
      check("k3_mem_req", 32'(mem_req), 32'd1);
      check("k3_if_gnt", 32'(if_gnt), 32'd0);
      @(negedge clk); drive_mem(1'b1, 32'hbad0bad0); #1;
      check("k4_mem_req", 32'(mem_req), 32'd1);
      check("k4_if_gnt", 32'(if_gnt), 32'd0);
      @(negedge clk); drive_mem(1'b0, 32'd0); #1;
      check("k5_if_rvalid", 32'(if_rvalid), 32'd0);
      check("k5_if_gnt", 32'(if_gnt), 32'd1);
      if_exp_q.push_back(32'h55);
      @(negedge clk); drive_if(1'b0, 32'd0); drive_mem(1'b1, 32'h55); #1;
      check("k6_mem_addr", mem_addr, 32'h204);
      @(negedge clk); drive_mem(1'b0, 32'd0); #1;
      check("k7_if_rvalid", 32'(if_rvalid), 32'd1);

      // kill coincident with ack
      @(negedge clk); drive_if(1'b1, 32'h208); #1;
      check("kc0_if_gnt", 32'(if_gnt), 32'd1);
      @(negedge clk); drive_if(1'b0, 32'd0); if_kill = 1'b1; drive_mem(1'b1, 32'h99); #1;
      @(negedge clk); if_kill = 1'b0; drive_mem(1'b0, 32'd0); #1;
      check("kc2_if_rvalid", 32'(if_rvalid), 32'd0);
      check("kc2_state", 32'(state_dbg), 32'd0);

      // store timeout: bus_err 8 cycles after mem_req rises
      @(negedge clk); drive_lsu(1'b1, 1'b1, 32'h5000, 32'h12345678, 4'hf); #1;
      check("t0_lsu_gnt", 32'(lsu_gnt), 32'd1);
      lsu_exp_q.push_back(32'd0);
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk); drive_lsu(1'b0, 1'b0, 32'd0, 32'd0, 4'd0); drive_mem(1'b0, 32'hffffffff); #1;
         check($sformatf("t%0d_mem_req", i), 32'(mem_req), 32'd1);
         check($sformatf("t%0d_bus_err", i), 32'(bus_err), 32'd0);
      end
      @(negedge clk); #1;
      check("t9_bus_err", 32'(bus_err), 32'd1);
      check("t9_lsu_rvalid", 32'(lsu_rvalid), 32'd1);
      check("t9_mem_req", 32'(mem_req), 32'd0);
      check("t9_state", 32'(state_dbg), 32'd0);
      @(negedge clk); #1;
      check("t10_bus_err", 32'(bus_err), 32'd0);

      // ack on the timeout cycle wins
      @(negedge clk); drive_lsu(1'b1, 1'b0, 32'h6000, 32'd0, 4'hf); #1;
      check("a0_lsu_gnt", 32'(lsu_gnt), 32'd1);
      lsu_exp_q.push_back(32'h77);
      for (int i = 1; i <= 7; i++) begin
         @(negedge clk); drive_lsu(1'b0, 1'b0, 32'd0, 32'd0, 4'd0); #1;
      end
      @(negedge clk); drive_mem(1'b1, 32'h77); #1;
      @(negedge clk); drive_mem(1'b0, 32'd0); #1;
      check("a9_bus_err", 32'(bus_err), 32'd0);
      check("a9_lsu_rvalid", 32'(lsu_rvalid), 32'd1);

      // fetch timeout returns zero data
      @(negedge clk); drive_if(1'b1, 32'h20c); #1;
      check("ft0_if_gnt", 32'(if_gnt), 32'd1);
      if_exp_q.push_back(32'd0);
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk); drive_if(1'b0, 32'd0); drive_mem(1'b0, 32'hffffffff); #1;
      end
      @(negedge clk); drive_mem(1'b0, 32'd0); #1;
      check("ft9_bus_err", 32'(bus_err), 32'd1);
      check("ft9_if_rvalid", 32'(if_rvalid), 32'd1);

      // if_kill in IDLE only blocks the grant that cycle; ack in IDLE ignored
      @(negedge clk); drive_if(1'b1, 32'h300); if_kill = 1'b1; drive_mem(1'b1, 32'h1); #1;
      check("ki0_if_gnt", 32'(if_gnt), 32'd0);
      @(negedge clk); if_kill = 1'b0; drive_mem(1'b0, 32'd0); #1;
      check("ki1_mem_req", 32'(mem_req), 32'd0);
      check("ki1_if_gnt", 32'(if_gnt), 32'd1);
      if_exp_q.push_back(32'h31);
      @(negedge clk); drive_if(1'b0, 32'd0); drive_mem(1'b1, 32'h31); #1;
      @(negedge clk); drive_mem(1'b0, 32'd0); #1;
      check("ki3_if_rvalid", 32'(if_rvalid), 32'd1);

      // reset in BUSY_LSU
      @(negedge clk); drive_lsu(1'b1, 1'b0, 32'h7000, 32'd0, 4'hf); #1;
      check("r0_lsu_gnt", 32'(lsu_gnt), 32'd1);
      @(negedge clk); drive_lsu(1'b0, 1'b0, 32'd0, 32'd0, 4'd0); rst = 1'b1; #1;
      check("r1_mem_req", 32'(mem_req), 32'd1);
      @(negedge clk); rst = 1'b0; drive_if(1'b1, 32'h304); #1;
      check("r2_mem_req", 32'(mem_req), 32'd0);
      check("r2_lsu_rvalid", 32'(lsu_rvalid), 32'd0);
      check("r2_if_gnt", 32'(if_gnt), 32'd1);
      if_exp_q.push_back(32'h3040);
      @(negedge clk); drive_if(1'b0, 32'd0); drive_mem(1'b1, 32'h3040); #1;
      check("r3_mem_addr", mem_addr, 32'h304);
      @(negedge clk); drive_mem(1'b0, 32'd0); #1;
      check("r4_if_rvalid", 32'(if_rvalid), 32'd1);
      @(negedge clk); #1;

      // continuous contention: grant order depends on the fairness build
      g = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         drive_if(1'b1, 32'h400);
         drive_lsu(1'b1, 1'b0, 32'h4000, 32'd0, 4'hf);
         drive_mem(1'b1, 32'ha5a50000);
         #1;
         if (lsu_gnt || if_gnt) begin
`ifdef ARB_FAIR_EN
            exp_is_if = (g % 5 == 4);
`else
            exp_is_if = 1'b0;
`endif
            check($sformatf("fair_g%0d_is_if", g), 32'(if_gnt), 32'(exp_is_if));
            if (if_gnt) if_exp_q.push_back(32'ha5a50000);
            else lsu_exp_q.push_back(32'ha5a50000);
            g++;
         end
      end
      check("fair_grant_count", 32'(g), 32'd10);
      @(negedge clk); drive_if(1'b0, 32'd0); drive_lsu(1'b0, 1'b0, 32'd0, 32'd0, 4'd0); #1;
      @(negedge clk); drive_mem(1'b0, 32'd0); #1;
      @(negedge clk); #3;

      check("if_q_drained", 32'(if_exp_q.size()), 32'd0);
      check("lsu_q_drained", 32'(lsu_exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-ported memory between the instruction-fetch requester and the load/store requester. It serialises accesses through a small FSM, gives LSU priority over IF, and bounds IF starvation. It discards fetch responses killed by a redirect, and aborts hung memory transactions with a timeout. It sits between the fetch/memory stages and the unified memory model.

## Interface
- STREAK_MAX, 4: maximum consecutive LSU grants while IF is waiting (fairness build only); range 1..15.
- TIMEOUT_CYC, 255: cycles in BUSY without mem_ack before abort; range 1..255.

- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- if_req  in  1  fetch request; held until if_gnt.
- if_addr  in  32  fetch address, word-aligned.
- if_kill  in  1  drop any pending fetch response.
- if_gnt  out  1  fetch request accepted this cycle.
- if_rvalid  out  1  fetch data valid, one-cycle pulse.
- if_rdata  out  32  fetch data.
- lsu_req  in  1  load/store request; held until lsu_gnt.
- lsu_we  in  1  1 = store.
- lsu_addr  in  32  data address.
- lsu_wdata  in  32  store data.
- lsu_be  in  4  byte enables.
- lsu_gnt  out  1  LSU request accepted this cycle.
- lsu_rvalid  out  1  load data valid, or store completion pulse.
- lsu_rdata  out  32  load data; 0 for stores.
- mem_req  out  1  memory access active.
- mem_we, mem_addr, mem_wdata, mem_be  out  1/32/32/4  registered copy of the granted request.
- mem_ack  in  1  memory completes the access; mem_rdata is valid.
- mem_rdata  in  32  memory read data.
- bus_err  out  1  one-cycle pulse on timeout abort.

## Operation
- States: IDLE, BUSY_IF, BUSY_LSU.
- IDLE:
  - Arbitration is combinational: lsu_gnt = lsu_req && !force_if; if_gnt = if_req && !lsu_gnt.
  - The granted request is captured into the mem_* registers.
  - The FSM moves to BUSY_IF or BUSY_LSU.
- BUSY_x:
  - mem_req = 1 and the mem_* fields are held stable.
  - No grants are issued.
  - On mem_ack: capture mem_rdata, pulse the matching rvalid next cycle, return to IDLE.
- Timeout counter:
  - Cleared on entry to BUSY and incremented each BUSY cycle without mem_ack.
  - At TIMEOUT_CYC it drops mem_req, pulses bus_err, returns to IDLE, and pulses the owner's rvalid with rdata = 0.
  - A killed fetch gets no rvalid.
- if_kill:
  - Asserted in BUSY_IF or coincident with mem_ack: sets kill_pend. The access still completes on the memory side, and its if_rvalid is suppressed.
  - Asserted in IDLE: no effect, except it blocks if_gnt in that cycle.
  - kill_pend clears on return to IDLE.
- lsu_rdata is 0 for stores; mem_rdata is ignored for stores.
- Reset value of every output: 0, including mem_* fields.
- Reset in any state: returns the FSM to IDLE next edge, drops mem_req, suppresses rvalid, and clears the counters.

## Timing
- Grant to mem_req: 1 cycle (registered).
- mem_ack to rvalid: 1 cycle (registered).
- Zero-wait memory: request at cycle 0 gives gnt at 0, mem_req at 1, mem_ack at 1, rvalid at 2.
- The next grant is possible at cycle 2, so peak throughput is one access every 2 cycles.
- Requesters must hold req and payload stable until gnt. Dropping req before gnt is allowed and cancels the request.
- Simultaneous if_req and lsu_req in IDLE: LSU wins unless force_if.
- mem_ack while in IDLE: ignored.
- mem_ack on the same cycle the timeout is reached: ack wins; no bus_err.

## Configuration
- ARB_FAIR_EN defined:
  - A 4-bit streak counter increments on each lsu_gnt while if_req is high, and saturates at STREAK_MAX.
  - force_if = (streak == STREAK_MAX) && if_req.
  - The streak counter clears on if_gnt, or when if_req is low in IDLE.
- ARB_FAIR_EN undefined:
  - force_if is 0, giving strict LSU priority.
  - No streak counter is built, and STREAK_MAX is unused.

## Test plan
- Fetch, zero-wait: if_req with if_addr=0x100, mem_ack in the same cycle as mem_req, mem_rdata=0x00500093 -> if_gnt at cycle 0, mem_req at cycles 1 only, if_rvalid at cycle 2 with 0x00500093.
- Contention: if_req and lsu_req (load 0x2000) both at cycle 0 -> lsu_gnt at cycle 0, if_gnt at cycle 2; mem_addr is 0x2000 then 0x100.
- Fairness: with ARB_FAIR_EN and STREAK_MAX=4, LSU and IF requesting continuously -> grant order L,L,L,L,I,L…; without the macro, IF is never granted.
- Kill: fetch granted, mem_ack delayed 3 cycles, if_kill pulsed at cycle 2 -> mem_req held until ack, no if_rvalid, next grant at the ack+1 cycle.
- Timeout: TIMEOUT_CYC=8, store granted, mem_ack never asserted -> bus_err and lsu_rvalid with rdata=0 eight cycles after mem_req rises, FSM in IDLE.
- Reset mid-BUSY_LSU: rst for 1 cycle -> mem_req=0, no rvalid, and a fresh if_req is granted the cycle after rst drops.
